// File: rtl/prom_bank_pkg.sv
// Shared types and constants for the runtime-loadable PROM bank.
package prom_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    DONE,
    ERROR
  } prom_state_t;

  localparam int CKSUM_W = 16;

  function automatic int total_depth(input int num_roms, input int addr_w);
    return num_roms * (1 << addr_w);
  endfunction

endpackage

// File: rtl/prom_bank_loadable_prom_chan.sv
// One PROM channel: simple dual-port RAM with a registered read port.
module prom_chan #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents survive a core reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking writes make a same-edge read of the written entry return the old value.
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prom_bank_loadable.sv
// NUM_ROMS synchronous-read PROM channels filled from the ioctl download stream,
// with load-completeness tracking, running checksum and read blanking while loading.
module prom_bank_loadable
  import prom_bank_pkg::*;
#(
  parameter int                   NUM_ROMS  = 6,
  parameter int                   ADDR_W    = 8,
  parameter int                   DATA_W    = 4,
  parameter int                   DL_ADDR_W = 25,
  parameter logic [DL_ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dl_active,
  input  logic                         dl_wr,
  input  logic [DL_ADDR_W-1:0]         dl_addr,
  input  logic [7:0]                   dl_data,
  input  logic [NUM_ROMS*ADDR_W-1:0]   rd_addr,
  output logic [NUM_ROMS*DATA_W-1:0]   rd_data,
  output logic                         loaded,
  output logic                         load_err,
  output logic [CKSUM_W-1:0]           checksum
);

  localparam int TOTAL = total_depth(NUM_ROMS, ADDR_W);
  localparam int CNT_W = ADDR_W + 8;
  localparam int SEL_W = DL_ADDR_W - ADDR_W;

  prom_state_t         state_q, state_d;
  logic                dl_active_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CKSUM_W-1:0]  checksum_q, checksum_d;
  logic                loaded_q, loaded_d;
  logic                load_err_q, load_err_d;
  logic                blank_q, blank_d;

  logic                 rise, fall, in_range, wr_en;
  logic [DL_ADDR_W-1:0] offset;
  logic [SEL_W-1:0]     chan_sel;
  logic [DATA_W-1:0]    wdata;
  logic [CNT_W-1:0]     count_base;
  logic [CKSUM_W-1:0]   checksum_base;
  logic [DATA_W-1:0]    chan_rdata [NUM_ROMS];

  // Only the low DATA_W bits of a download byte are stored.
  logic unused_dl_bits;
  assign unused_dl_bits = ^dl_data;

  assign offset   = dl_addr - BASE_ADDR;
  assign chan_sel = offset[DL_ADDR_W-1:ADDR_W];
  assign wdata    = dl_data[DATA_W-1:0];
  assign in_range = (dl_addr >= BASE_ADDR) && (offset < DL_ADDR_W'(TOTAL));
  assign rise     = dl_active && !dl_active_q;
  assign fall     = !dl_active && dl_active_q;
  // The falling-edge cycle is still LOADING, so its write lands before the count is judged.
  assign wr_en    = dl_wr && in_range && (rise || state_q == LOADING);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves a latch behind.
    state_d       = state_q;
    loaded_d      = loaded_q;
    load_err_d    = load_err_q;
    count_base    = rise ? '0 : count_q;
    checksum_base = rise ? '0 : checksum_q;
    count_d       = count_base;
    checksum_d    = checksum_base;
    blank_d       = (state_q == LOADING);

    if (wr_en) begin
      if (count_base != '1) count_d = count_base + 1'b1;
      checksum_d = checksum_base + CKSUM_W'(wdata);
    end

    if (rise) begin
      state_d    = LOADING;
      loaded_d   = 1'b0;
      load_err_d = 1'b0;
    end else begin
      case (state_q)
        LOADING: begin
          if (fall) begin
            if (count_d == CNT_W'(TOTAL)) begin
              state_d = DONE;
            end else begin
              state_d    = ERROR;
              load_err_d = 1'b1;
            end
          end
        end
        DONE:    loaded_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Blanking resets high so rd_data reads as zero the moment reset asserts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dl_active_q <= 1'b0;
      count_q     <= '0;
      checksum_q  <= '0;
      loaded_q    <= 1'b0;
      load_err_q  <= 1'b0;
      blank_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      dl_active_q <= dl_active;
      count_q     <= count_d;
      checksum_q  <= checksum_d;
      loaded_q    <= loaded_d;
      load_err_q  <= load_err_d;
      blank_q     <= blank_d;
    end
  end

  for (genvar k = 0; k < NUM_ROMS; k++) begin : g_chan
    prom_chan #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_chan (
      .clk  (clk),
      .we   (wr_en && (chan_sel == SEL_W'(k))),
      .waddr(offset[ADDR_W-1:0]),
      .wdata(wdata),
      .raddr(rd_addr[k*ADDR_W +: ADDR_W]),
      .rdata(chan_rdata[k])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_ROMS; k++) begin
      if (!blank_q) rd_data[k*DATA_W +: DATA_W] = chan_rdata[k];
    end
  end

  assign loaded   = loaded_q;
  assign load_err = load_err_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_prom_bank_loadable.sv
// Directed-sequence bench with randomized data, checked against a flat-array download model.
module tb_prom_bank_loadable;

  localparam int          NUM_ROMS  = 6;
  localparam int          ADDR_W    = 8;
  localparam int          DATA_W    = 4;
  localparam int          DL_ADDR_W = 25;
  localparam logic [24:0] BASE      = 25'h100;
  localparam int          DEPTH     = 256;
  localparam int          TOTAL     = NUM_ROMS * DEPTH;

  logic                        clk;
  logic                        reset;
  logic                        dl_active;
  logic                        dl_wr;
  logic [DL_ADDR_W-1:0]        dl_addr;
  logic [7:0]                  dl_data;
  logic [NUM_ROMS*ADDR_W-1:0]  rd_addr;
  logic [NUM_ROMS*DATA_W-1:0]  rd_data;
  logic                        loaded;
  logic                        load_err;
  logic [15:0]                 checksum;

  prom_bank_loadable #(
    .NUM_ROMS (NUM_ROMS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DL_ADDR_W(DL_ADDR_W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dl_active(dl_active),
    .dl_wr    (dl_wr),
    .dl_addr  (dl_addr),
    .dl_data  (dl_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .loaded   (loaded),
    .load_err (load_err),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: contents by download offset, plus per-download write count and byte sum.
  logic [3:0]  m_mem [TOTAL];
  int          m_count;
  logic [15:0] m_cks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_begin();
    m_count = 0;
    m_cks   = 16'h0;
  endtask

  task automatic m_write(input logic [24:0] addr, input logic [7:0] d);
    int off;
    if (addr < BASE) return;
    off = int'(addr - BASE);
    if (off >= TOTAL) return;
    m_mem[off] = d[3:0];
    if (m_count < 65535) m_count++;
    m_cks = m_cks + 16'(d[3:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dl_begin(input bit with_wr, input int off, input logic [7:0] d);
    dl_active = 1'b1;
    dl_wr     = with_wr;
    dl_addr   = BASE + 25'(off);
    dl_data   = d;
    m_begin();
    if (with_wr) m_write(dl_addr, d);
    tick();
    dl_wr = 1'b0;
    check("rise_clears_loaded", 32'(loaded), 32'd0);
    check("rise_clears_err", 32'(load_err), 32'd0);
  endtask

  task automatic dl_byte(input logic [24:0] addr, input logic [7:0] d);
    dl_wr   = 1'b1;
    dl_addr = addr;
    dl_data = d;
    if (dl_active) m_write(addr, d);
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic dl_end(input bit with_wr, input int off, input logic [7:0] d);
    dl_active = 1'b0;
    dl_wr     = with_wr;
    dl_addr   = BASE + 25'(off);
    dl_data   = d;
    if (with_wr) m_write(dl_addr, d);
    tick();
    dl_wr = 1'b0;
    check("loaded_not_early", 32'(loaded), 32'd0);
    tick();
    check("loaded", 32'(loaded), 32'(m_count == TOTAL));
    check("load_err", 32'(load_err), 32'(m_count != TOTAL));
    check("checksum", 32'(checksum), 32'(m_cks));
  endtask

  // Writes every offset once; framed puts the first and last byte on the dl_active edges.
  task automatic full_load(input bit framed, input bit rnd, input int count);
    logic [7:0] d;
    for (int a = 0; a < count; a++) begin
      d = rnd ? 8'($urandom) : 8'((a * 7) & 255);
      if (a == 0) begin
        dl_begin(framed, 0, d);
        if (!framed) dl_byte(BASE, d);
      end else if (a == count - 1 && framed) begin
        dl_end(1'b1, a, d);
      end else begin
        dl_byte(BASE + 25'(a), d);
      end
    end
    if (!framed) dl_end(1'b0, 0, 8'h00);
  endtask

  task automatic check_reads(input int n);
    logic [7:0] ra [NUM_ROMS];
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < NUM_ROMS; k++) begin
        ra[k] = 8'($urandom);
        rd_addr[k*ADDR_W +: ADDR_W] = ra[k];
      end
      tick();
      for (int k = 0; k < NUM_ROMS; k++)
        check("rd_data", 32'(rd_data[k*DATA_W +: DATA_W]), 32'(m_mem[k*DEPTH + int'(ra[k])]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = '0;
    dl_data   = '0;
    rd_addr   = '0;
    m_begin();
    #1;
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_loaded", 32'(loaded), 32'd0);
    check("reset_load_err", 32'(load_err), 32'd0);
    check("reset_checksum", 32'(checksum), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("idle_loaded", 32'(loaded), 32'd0);

    // Full load with the (a*7) pattern.
    full_load(1'b0, 1'b0, TOTAL);
    rd_addr = '0;
    rd_addr[2*ADDR_W +: ADDR_W] = 8'h05;
    tick();
    check("ch2_entry5", 32'(rd_data[2*DATA_W +: DATA_W]), 32'h3);
    check_reads(4);

    // A write with dl_active low must be ignored.
    dl_byte(BASE + 25'd3, 8'hFF);
    rd_addr = '0;
    rd_addr[0 +: ADDR_W] = 8'h03;
    tick();
    check("idle_write_ignored", 32'(rd_data[0 +: DATA_W]), 32'(m_mem[3]));
    check("idle_write_cksum", 32'(checksum), 32'(m_cks));

    // Short load ends in error; a framed full load then recovers.
    full_load(1'b0, 1'b1, TOTAL - 1);
    full_load(1'b1, 1'b1, TOTAL);
    check_reads(3);

    // Out-of-range writes leave count, checksum and contents alone.
    dl_begin(1'b0, 0, 8'h00);
    dl_byte(25'h0FF, 8'hA5);
    dl_byte(25'h700, 8'hA5);
    check("oor_checksum", 32'(checksum), 32'(m_cks));
    for (int a = 0; a < TOTAL; a++) dl_byte(BASE + 25'(a), 8'($urandom));
    dl_end(1'b0, 0, 8'h00);
    check_reads(3);

    // Preload channel 0 entry 0x10 with 0x9.
    dl_begin(1'b0, 0, 8'h00);
    for (int a = 0; a < TOTAL; a++) dl_byte(BASE + 25'(a), (a == 16) ? 8'hC9 : 8'($urandom));
    dl_end(1'b0, 0, 8'h00);
    rd_addr = '0;
    rd_addr[0 +: ADDR_W] = 8'h10;
    tick();
    check("preload_0x10", 32'(rd_data[0 +: DATA_W]), 32'h9);

    // Blanking, with a duplicate write standing in for the skipped entry 0x10.
    dl_begin(1'b0, 0, 8'h00);
    tick();
    check("blank_second_cycle", 32'(rd_data), 32'd0);
    for (int a = 0; a < TOTAL; a++) begin
      if (a == 16) dl_byte(BASE + 25'd17, 8'($urandom));
      else dl_byte(BASE + 25'(a), 8'($urandom));
    end
    check("blank_late", 32'(rd_data), 32'd0);
    dl_end(1'b0, 0, 8'h00);
    check("unblank_0x10", 32'(rd_data[0 +: DATA_W]), 32'h9);

    // Reset in the middle of a download.
    dl_begin(1'b0, 0, 8'h00);
    for (int a = 0; a < 700; a++) dl_byte(BASE + 25'(a), 8'($urandom));
    reset     = 1'b1;
    dl_active = 1'b0;
    #1;
    check("midreset_loaded", 32'(loaded), 32'd0);
    check("midreset_err", 32'(load_err), 32'd0);
    check("midreset_rd", 32'(rd_data), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    check("after_reset_loaded", 32'(loaded), 32'd0);
    check_reads(3);

    // Fresh framed load with the pattern after the interrupted one.
    full_load(1'b1, 1'b0, TOTAL);
    rd_addr = '0;
    rd_addr[5*ADDR_W +: ADDR_W] = 8'hFF;
    tick();
    check("rise_byte", 32'(rd_data[0 +: DATA_W]), 32'(m_mem[0]));
    check("fall_byte", 32'(rd_data[5*DATA_W +: DATA_W]), 32'(m_mem[TOTAL-1]));
    check_reads(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
